mb_seq_multiplier: RTL
======================

Name: mb_seq_multiplier

Overview:
- Sequential radix-4 Modified Booth multiplier core, sitting directly downstream of the MB encoder.
- Consumes the encoder's per-digit sign/one/two vectors for the multiplier, plus the two's-complement multiplicand.
- Iterates one Booth digit per clock: forms the partial product, shifts it, adds it into a signed accumulator.
- Returns the 2N-bit signed product over a valid/ready handshake.

Parameters:
- N, 8, operand width in bits; must be even.
- DIGITS, N/2, number of Booth digits (localparam, derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- b  input  N  multiplicand, two's complement.
- sign  input  DIGITS  digit sign from the MB encoder (1 = negative).
- one  input  DIGITS  digit magnitude 1.
- two  input  DIGITS  digit magnitude 2.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- p  output  2N  signed product.
- out_err  output  1  at least one digit of this operation had one=two=1.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, p=0, out_err=0, accumulator=0, digit counter=0.
  - Reset mid-operation discards the operation. No product is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture b (sign-extended to 2N), sign, one and two into registers. Clear the accumulator, counter and error. Go to CALC.
  - CALC: in_ready=0. Each cycle, process digit k=counter.
    - pp = 0 if one=two=0 or one=two=1.
    - pp = B if one=1.
    - pp = B<<1 if two=1.
    - If sign[k]=1, negate pp (two's complement, 2N wide).
    - acc <= acc + (pp << 2k), modulo 2^2N.
    - one=two=1 sets err.
    - After k=DIGITS-1: load p from the final sum, set out_err from err, assert out_valid, go to DONE.
  - DONE: out_valid=1. p and out_err are held stable until out_ready=1. On out_valid&out_ready, go to IDLE, with out_valid=0 next cycle.
- Latency and throughput:
  - Acceptance at edge t. out_valid rises after edge t+DIGITS (4 cycles for N=8).
  - in_ready is low from CALC entry until the cycle after the handshake completes.
  - No bypass from DONE to IDLE: a new operand cannot be accepted in the same cycle out_ready completes.
  - Back-to-back throughput is one operation per DIGITS+2 cycles.
- Inputs:
  - in_valid while in_ready=0 is ignored; the operand is not captured.
  - Inputs are sampled only at the accept edge. Later changes have no effect.
- Arithmetic and sign handling:
  - All arithmetic is 2N-bit two's complement; overflow is impossible for legal digits.
  - Digit (sign=0, one=0, two=0) contributes 0.
  - The encoder maps -0 to +0, so sign=1 with zero magnitude also contributes 0. No special case is needed; negating 0 yields 0.
- out_err: sticky within one operation, cleared at the next accept. It does not alter the handshake.

Decomposition:
- Shared package mb_pkg:
  - State enumeration (IDLE, CALC, DONE).
  - Digit-decode helper constants.
  - Derivation of DIGITS from N.
- One natural sub-module, mb_pp_gen: combinational partial-product generator.
  - Inputs: B (2N), sign, one, two.
  - Outputs: pp (2N), illegal.
  - Reusable by a future array or parallel multiplier.
- Counter, FSM and accumulator stay in mb_seq_multiplier.

Test Plan:
- 3 × 5: b=8'h05, sign=4'b0001, one=4'b0011, two=4'b0000 (encoding of 3), out_ready=1 -> out_valid 4 cycles after accept, p=16'h000F, out_err=0.
- 127 × -128: b=8'h80, multiplier a=8'h7F via the encoder -> p=16'hC080. Then -128 × -128 (a=8'h80, digits sign=4'b1000, two=4'b1000) -> p=16'h4000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> p stable, in_ready=0, and a new in_valid is not captured. Raise out_ready -> out_valid drops next cycle, in_ready=1.
- Reset mid-CALC: rst_n=0 at digit k=2 -> out_valid=0, p=0 immediately. After release in IDLE, no spurious product; a fresh 3×5 yields 16'h000F.
- Illegal digit: one=4'b0100, two=4'b0100, sign=0, b=8'h01 -> digit 2 contributes 0, p=16'h0000, out_err=1. The next legal operation has out_err=0.
- Exhaustive random: all 65536 (a,b) pairs through an encoder model -> p equals $signed(a)*$signed(b) in every case.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared types and constants for the radix-4 Modified Booth multiplier family.
// Digit magnitudes are encoded as {two, one}, matching the MB encoder outputs.
package mb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] DIG_ZERO    = 2'b00;
  localparam logic [1:0] DIG_ONE     = 2'b01;
  localparam logic [1:0] DIG_TWO     = 2'b10;
  localparam logic [1:0] DIG_ILLEGAL = 2'b11;

  function automatic int digits_of(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/mb_pp_gen.sv
// Combinational Booth partial-product generator: selects 0, B or 2B from one digit,
// then applies the digit sign. A digit with one=two=1 yields zero and flags illegal.
module mb_pp_gen
  import mb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] b,
  input  logic         sign,
  input  logic         one,
  input  logic         two,
  output logic [W-1:0] pp,
  output logic         illegal
);

  logic [W-1:0] mag;

  always_comb begin
    mag = '0;
    case ({two, one})
      DIG_ONE: mag = b;
      DIG_TWO: mag = b << 1;
      default: mag = '0;
    endcase
    // Negating a zero magnitude gives zero, so the encoder's -0 needs no special case.
    pp      = sign ? -mag : mag;
    illegal = one & two;
  end

endmodule

// File: rtl/mb_seq_multiplier.sv
// Sequential radix-4 Modified Booth multiplier: one Booth digit per clock into a
// 2N-bit accumulator, with valid/ready handshakes on operands and product.
module mb_seq_multiplier
  import mb_pkg::*;
#(
  parameter int  N      = 8,
  localparam int DIGITS = digits_of(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        b,
  input  logic [DIGITS-1:0]   sign,
  input  logic [DIGITS-1:0]   one,
  input  logic [DIGITS-1:0]   two,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*N-1:0]      p,
  output logic                out_err
);

  localparam int W     = 2 * N;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        acc_q;
  logic [W-1:0]        acc_d;
  logic [W-1:0]        p_q;
  logic [W-1:0]        pp;
  logic [DIGITS-1:0]   sign_q;
  logic [DIGITS-1:0]   one_q;
  logic [DIGITS-1:0]   two_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                err_d;
  logic                illegal;
  logic                out_valid_q;
  logic                out_err_q;
  logic                last_digit;

  mb_pp_gen #(.W(W)) u_pp_gen (
    .b       (b_q),
    .sign    (sign_q[cnt_q]),
    .one     (one_q[cnt_q]),
    .two     (two_q[cnt_q]),
    .pp      (pp),
    .illegal (illegal)
  );

  // Digit k has weight 4^k, so its partial product is shifted left by 2k.
  always_comb begin
    acc_d      = acc_q + (pp << {cnt_q, 1'b0});
    err_d      = err_q | illegal;
    last_digit = (cnt_q == CNT_W'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      b_q         <= '0;
      sign_q      <= '0;
      one_q       <= '0;
      two_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      p_q         <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            b_q     <= {{N{b[N-1]}}, b};
            sign_q  <= sign;
            one_q   <= one;
            two_q   <= two;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          err_q <= err_d;
          if (last_digit) begin
            cnt_q       <= '0;
            p_q         <= acc_d;
            out_err_q   <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Returning through IDLE means a new operand waits one cycle after the handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign out_err   = out_err_q;

endmodule
